ex_mem_stage: RTL and testbench

//  Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline.

---
 rtl/ex_mem_stage_if.sv | 49 ++++
 rtl/ex_mem_stage.sv | 141 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// Purpose: bundles the ID/EX-side inputs and EX/MEM register outputs of ex_mem_stage.
// Latency: none, wires only.
// Backpressure: stall/flush travel with the bundle; there is no ready handshake.
interface ex_mem_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  // ID/EX side
  logic          in_valid;
  logic [3:0]    operation;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [DW-1:0] imm;
  logic          alu_src;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic [DW-1:0] mem_fwd_data;
  logic [DW-1:0] wb_fwd_data;
  logic [RW-1:0] rd_addr;
  logic          reg_write;
  logic          mem_read;
  logic          mem_write;
  logic          stall;
  logic          flush;
  // EX/MEM register side
  logic          out_valid;
  logic [DW-1:0] alu_result_q;
  logic [DW-1:0] store_data_q;
  logic [RW-1:0] rd_addr_q;
  logic          reg_write_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic          zero_q;
  logic          ovf_q;

  modport master (
    output in_valid, operation, rs_val, rt_val, imm, alu_src, fwd_a_sel, fwd_b_sel,
           mem_fwd_data, wb_fwd_data, rd_addr, reg_write, mem_read, mem_write, stall, flush,
    input  out_valid, alu_result_q, store_data_q, rd_addr_q, reg_write_q, mem_read_q,
           mem_write_q, zero_q, ovf_q
  );

  modport slave (
    input  in_valid, operation, rs_val, rt_val, imm, alu_src, fwd_a_sel, fwd_b_sel,
           mem_fwd_data, wb_fwd_data, rd_addr, reg_write, mem_read, mem_write, stall, flush,
    output out_valid, alu_result_q, store_data_q, rd_addr_q, reg_write_q, mem_read_q,
           mem_write_q, zero_q, ovf_q
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Purpose: MIPS execute stage (operand forwarding, ALU) plus the EX/MEM pipeline register.
// Latency: 1 cycle; priority per edge is reset > flush > stall > load; in_valid=0 loads a bubble.
// Backpressure: stall holds every register (upstream keeps its inputs); EX_OVF_TRAP_EN enables the overflow trap.
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_stage_if.slave  bus
);

  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd7;

  logic [DW-1:0] op_a;
  logic [DW-1:0] rt_fwd;
  logic [DW-1:0] op_b;
  logic [DW-1:0] op_b_eff;
  logic [DW-1:0] alu_res;
  logic          is_arith;
  logic          ovf_det;

  logic          out_valid_d,    out_valid_q;
  logic [DW-1:0] alu_result_d,   alu_result_q;
  logic [DW-1:0] store_data_d,   store_data_q;
  logic [RW-1:0] rd_addr_d,      rd_addr_q;
  logic          reg_write_d,    reg_write_q;
  logic          mem_read_d,     mem_read_q;
  logic          mem_write_d,    mem_write_q;
  logic          zero_d,         zero_q;
  logic          ovf_d,          ovf_q;

  // Forwarding muxes, alu_src select and the ALU itself; SUB is done as A + (~B + 1).
  always_comb begin
    case (bus.fwd_a_sel)
      2'd1:    op_a = bus.mem_fwd_data;
      2'd2:    op_a = bus.wb_fwd_data;
      default: op_a = bus.rs_val;
    endcase
    case (bus.fwd_b_sel)
      2'd1:    rt_fwd = bus.mem_fwd_data;
      2'd2:    rt_fwd = bus.wb_fwd_data;
      default: rt_fwd = bus.rt_val;
    endcase
    op_b     = bus.alu_src ? bus.imm : rt_fwd;
    op_b_eff = (bus.operation == OP_SUB) ? (~op_b + 1'b1) : op_b;
    is_arith = (bus.operation == OP_ADD) || (bus.operation == OP_SUB);
    case (bus.operation)
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD,
      OP_SUB:  alu_res = op_a + op_b_eff;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  // Signed overflow: both addends share a sign the sum does not.
  always_comb begin
    ovf_det = is_arith && (op_a[DW-1] == op_b_eff[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
  end
`else
  // Overflow wraps silently; the trap path is absent.
  always_comb begin
    ovf_det = 1'b0 & is_arith;
  end
`endif

  // Next EX/MEM contents: flush or an invalid slot inserts a bubble, stall holds.
  always_comb begin
    out_valid_d  = out_valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    rd_addr_d    = rd_addr_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      out_valid_d  = 1'b0;
      alu_result_d = '0;
      store_data_d = '0;
      rd_addr_d    = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      zero_d       = 1'b0;
      ovf_d        = 1'b0;
    end else if (!bus.stall) begin
      out_valid_d  = 1'b1;
      alu_result_d = alu_res;
      store_data_d = rt_fwd;
      rd_addr_d    = bus.rd_addr;
      reg_write_d  = bus.reg_write & ~ovf_det;
      mem_read_d   = bus.mem_read  & ~ovf_det;
      mem_write_d  = bus.mem_write & ~ovf_det;
      zero_d       = (alu_res == '0);
      ovf_d        = ovf_det;
    end
  end

  // EX/MEM register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      rd_addr_q    <= rd_addr_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.alu_result_q = alu_result_q;
  assign bus.store_data_q = store_data_q;
  assign bus.rd_addr_q    = rd_addr_q;
  assign bus.reg_write_q  = reg_write_q;
  assign bus.mem_read_q   = mem_read_q;
  assign bus.mem_write_q  = mem_write_q;
  assign bus.zero_q       = zero_q;
  assign bus.ovf_q        = ovf_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios then random traffic against a reference model.
// Driver applies inputs on the falling edge and queues the expected register contents.
// Monitor samples 1 time unit after each rising edge and compares against the queue head.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        alu_src;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] memf;
    logic [31:0] wbf;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        stall;
    logic        flush;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        z;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  ex_mem_stage_if #(.DW(32), .RW(5)) bus ();

  ex_mem_stage #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t expq[$];
  exp_t model_q;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;

  // Reference model: what the EX/MEM register should hold after one edge.
  function automatic exp_t model(exp_t cur, stim_t s);
    exp_t        n;
    logic [31:0] a, bf, b, nb;
    longint      sum;
    bit          ovf;
    n = '0;
    if (!s.rst_n) return n;
    if (s.flush) return n;
    if (s.stall) return cur;
    if (!s.in_valid) return n;
    a  = (s.fa == 2'd1) ? s.memf : (s.fa == 2'd2) ? s.wbf : s.rs;
    bf = (s.fb == 2'd1) ? s.memf : (s.fb == 2'd2) ? s.wbf : s.rt;
    b  = s.alu_src ? s.imm : bf;
    nb = 32'd0 - b;
    ovf = 1'b0;
    case (s.op)
      4'd3: n.res = a | b;
      4'd7: n.res = a & b;
      4'd4: begin
        n.res = a + b;
        sum = longint'($signed(a)) + longint'($signed(b));
        ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
      end
      4'd5: begin
        n.res = a - b;
        sum = longint'($signed(a)) + longint'($signed(nb));
        ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
      end
      default: n.res = 32'd0;
    endcase
`ifndef EX_OVF_TRAP_EN
    ovf = 1'b0;
`endif
    n.valid = 1'b1;
    n.sd    = bf;
    n.rd    = s.rd;
    n.rw    = s.rw && !ovf;
    n.mr    = s.mr && !ovf;
    n.mw    = s.mw && !ovf;
    n.z     = (n.res == 32'd0);
    n.ovf   = ovf;
    return n;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n    = ($urandom_range(0, 49) != 0);
    s.in_valid = ($urandom_range(0, 7) != 0);
    case ($urandom_range(0, 4))
      0: s.op = 4'd3;
      1: s.op = 4'd4;
      2: s.op = 4'd5;
      3: s.op = 4'd7;
      default: s.op = 4'($urandom_range(0, 15));
    endcase
    s.rs      = rand_word();
    s.rt      = rand_word();
    s.imm     = rand_word();
    s.alu_src = 1'($urandom_range(0, 1));
    s.fa      = 2'($urandom_range(0, 3));
    s.fb      = 2'($urandom_range(0, 3));
    s.memf    = rand_word();
    s.wbf     = rand_word();
    s.rd      = 5'($urandom_range(0, 31));
    s.rw      = 1'($urandom_range(0, 1));
    s.mr      = 1'($urandom_range(0, 1));
    s.mw      = 1'($urandom_range(0, 1));
    s.stall   = ($urandom_range(0, 5) == 0);
    s.flush   = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Drive one cycle of inputs and queue the expected register contents.
  task automatic apply(input stim_t s);
    @(negedge clk);
    rst_n            = s.rst_n;
    bus.in_valid     = s.in_valid;
    bus.operation    = s.op;
    bus.rs_val       = s.rs;
    bus.rt_val       = s.rt;
    bus.imm          = s.imm;
    bus.alu_src      = s.alu_src;
    bus.fwd_a_sel    = s.fa;
    bus.fwd_b_sel    = s.fb;
    bus.mem_fwd_data = s.memf;
    bus.wb_fwd_data  = s.wbf;
    bus.rd_addr      = s.rd;
    bus.reg_write    = s.rw;
    bus.mem_read     = s.mr;
    bus.mem_write    = s.mw;
    bus.stall        = s.stall;
    bus.flush        = s.flush;
    model_q = model(model_q, s);
    expq.push_back(model_q);
    mon_en = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: compare the register outputs to the queue head after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
          e = expq.pop_front();
          vectors++;
          chk("out_valid",    32'(bus.out_valid),    32'(e.valid));
          chk("alu_result_q", bus.alu_result_q,      e.res);
          chk("store_data_q", bus.store_data_q,      e.sd);
          chk("rd_addr_q",    32'(bus.rd_addr_q),    32'(e.rd));
          chk("reg_write_q",  32'(bus.reg_write_q),  32'(e.rw));
          chk("mem_read_q",   32'(bus.mem_read_q),   32'(e.mr));
          chk("mem_write_q",  32'(bus.mem_write_q),  32'(e.mw));
          chk("ovf_q",        32'(bus.ovf_q),        32'(e.ovf));
          if (e.valid) chk("zero_q", 32'(bus.zero_q), 32'(e.z));
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    stim_t s;
    model_q = '0;
    rst_n   = 1'b0;

    // Reset with random inputs, then idle bubbles.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim();
      s.rst_n = 1'b0;
      apply(s);
    end
    apply(quiet());
    apply(quiet());

    // ADD 5 + imm 7 -> 12.
    s = quiet(); s.in_valid = 1; s.op = 4'd4; s.rs = 32'd5; s.imm = 32'd7;
    s.alu_src = 1; s.rd = 5'd9; s.rw = 1; s.rt = 32'd3;
    apply(s);

    // SUB of two forwarded equal values -> zero; store data from wb path.
    s = quiet(); s.in_valid = 1; s.op = 4'd5; s.fa = 2'd1; s.memf = 32'h10;
    s.fb = 2'd2; s.wbf = 32'h10; s.rs = 32'h55; s.rt = 32'h66; s.mw = 1;
    apply(s);

    // AND -> 0xF0, then stall with new inputs, then stall+flush.
    s = quiet(); s.in_valid = 1; s.op = 4'd7; s.rs = 32'hFF; s.imm = 32'h1F0;
    s.alu_src = 1; s.rd = 5'd4; s.rw = 1; s.mr = 1;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim();
      s.rst_n = 1; s.stall = 1; s.flush = 0;
      apply(s);
    end
    s = rand_stim();
    s.rst_n = 1; s.stall = 1; s.flush = 1; s.in_valid = 1;
    apply(s);

    // Signed overflow on ADD 0x7FFFFFFF + 1.
    s = quiet(); s.in_valid = 1; s.op = 4'd4; s.rs = 32'h7FFF_FFFF; s.imm = 32'd1;
    s.alu_src = 1; s.rw = 1; s.rd = 5'd2;
    apply(s);

    // Undefined op still copies controls; then reset clears everything.
    s = quiet(); s.in_valid = 1; s.op = 4'hA; s.rs = 32'h1234; s.rt = 32'h99;
    s.mw = 1; s.rd = 5'd7;
    apply(s);
    s = rand_stim();
    s.rst_n = 0;
    apply(s);

    // Random traffic.
    for (int i = 0; i < 600; i++) apply(rand_stim());

    @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
